// File: rtl/gcd_stream_driver.sv
// Stream initiator for a val/rdy GCD unit: issues LFSR operand pairs, folds results
// into a rotate-xor checksum, and counts RUN cycles for throughput measurement.
module gcd_stream_driver #(
    parameter int unsigned W     = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_reqs,
    input  logic [W-1:0]     seed,
    output logic [W-1:0]     operands_bits_A,
    output logic [W-1:0]     operands_bits_B,
    output logic             operands_val,
    input  logic             operands_rdy,
    input  logic [W-1:0]     result_bits_data,
    input  logic             result_val,
    output logic             result_rdy,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [W-1:0]     checksum,
    output logic [CNT_W-1:0] resp_count,
    output logic [31:0]      cycle_count
);

    localparam int unsigned H = W / 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] req_lim, sent, recv, sent_next;
    logic [W-1:0]     lfsr, lfsr_step, lfsr_next;
    logic             op_fire, res_fire, launch, val_next;

    assign op_fire   = operands_val && operands_rdy;
    assign res_fire  = result_val && result_rdy;
    assign launch    = start && (state != RUN);
    assign lfsr_step = {lfsr[W-2:0], lfsr[W-1] ^ lfsr[W-3] ^ lfsr[W-4] ^ lfsr[W-6]};

    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign result_rdy = (state == RUN) && (recv < req_lim);
    assign resp_count = recv;

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = RUN;
            RUN:        if (recv == req_lim) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Operand registers are loaded from the post-fire LFSR so a new pair appears the cycle after a fire.
    always_comb begin
        lfsr_next = op_fire ? lfsr_step : lfsr;
        sent_next = sent + (op_fire ? CNT_W'(1) : CNT_W'(0));
        val_next  = (state == RUN) && (state_next == RUN) && (sent_next < req_lim);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            req_lim         <= '0;
            lfsr            <= W'(1);
            sent            <= '0;
            recv            <= '0;
            checksum        <= '0;
            err             <= 1'b0;
            cycle_count     <= '0;
            operands_bits_A <= '0;
            operands_bits_B <= '0;
            operands_val    <= 1'b0;
        end else begin
            state <= state_next;
            if (launch) begin
                req_lim      <= num_reqs;
                lfsr         <= (seed == '0) ? W'(1) : seed;
                sent         <= '0;
                recv         <= '0;
                checksum     <= '0;
                err          <= 1'b0;
                cycle_count  <= '0;
                operands_val <= 1'b0;
            end else if (state == RUN) begin
                lfsr            <= lfsr_next;
                sent            <= sent_next;
                operands_bits_A <= lfsr_next;
                operands_bits_B <= {lfsr_next[H-1:0], lfsr_next[W-1:H]};
                operands_val    <= val_next;
                if (res_fire) begin
                    recv     <= recv + CNT_W'(1);
                    checksum <= {checksum[W-2:0], checksum[W-1]} ^ result_bits_data;
                    if (recv >= sent) err <= 1'b1;
                end
                if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_gcd_stream_driver.sv
// Directed bench for gcd_stream_driver; the bench itself plays the GCD unit with a fixed result latency.
module tb_gcd_stream_driver;

    localparam int W     = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset, start;
    logic [CNT_W-1:0] num_reqs;
    logic [W-1:0]     seed;
    logic [W-1:0]     operands_bits_A, operands_bits_B;
    logic             operands_val, operands_rdy;
    logic [W-1:0]     result_bits_data;
    logic             result_val, result_rdy;
    logic             busy, done, err;
    logic [W-1:0]     checksum;
    logic [CNT_W-1:0] resp_count;
    logic [31:0]      cycle_count;

    always #5 clk = ~clk;

    gcd_stream_driver #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .num_reqs(num_reqs), .seed(seed),
        .operands_bits_A(operands_bits_A), .operands_bits_B(operands_bits_B),
        .operands_val(operands_val), .operands_rdy(operands_rdy),
        .result_bits_data(result_bits_data), .result_val(result_val), .result_rdy(result_rdy),
        .busy(busy), .done(done), .err(err), .checksum(checksum),
        .resp_count(resp_count), .cycle_count(cycle_count)
    );

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic             model_on, inj_val, start_req;
    logic [W-1:0]     inj_data, req_seed, exp_a, exp_b;
    logic [CNT_W-1:0] req_n;
    int               lat, stall, ncyc, busy_cyc;
    bit               saw_val;
    logic [W-1:0]     rq_data[$];
    int               rq_due[$];
    logic [W-1:0]     log_a[$], log_b[$];

    function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != '0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // One clock of stimulus: drive at the falling edge, record fires that the next rising edge will take.
    task automatic cyc();
        @(negedge clk);
        start     = start_req;
        start_req = 1'b0;
        num_reqs  = req_n;
        seed      = req_seed;
        if (busy) busy_cyc++;
        if (operands_val) saw_val = 1'b1;
        operands_rdy = model_on;
        if (operands_val && stall > 0) begin
            check("stall_a", operands_bits_A, exp_a);
            check("stall_b", operands_bits_B, exp_b);
            operands_rdy = 1'b0;
            stall--;
        end
        result_val       = 1'b0;
        result_bits_data = '0;
        if (inj_val) begin
            result_val       = 1'b1;
            result_bits_data = inj_data;
        end else if (model_on && rq_due.size() > 0 && rq_due[0] <= ncyc) begin
            result_val       = 1'b1;
            result_bits_data = rq_data[0];
        end
        #1;
        if (operands_val && operands_rdy) begin
            log_a.push_back(operands_bits_A);
            log_b.push_back(operands_bits_B);
            rq_data.push_back(gcd(operands_bits_A, operands_bits_B));
            rq_due.push_back(ncyc + lat);
        end
        if (result_val && result_rdy) begin
            if (inj_val) inj_val = 1'b0;
            else begin
                void'(rq_data.pop_front());
                void'(rq_due.pop_front());
            end
        end
        ncyc++;
    endtask

    task automatic run(input int n, input logic [W-1:0] s, input int budget);
        int k;
        log_a.delete();
        log_b.delete();
        busy_cyc  = 0;
        saw_val   = 1'b0;
        req_n     = CNT_W'(n);
        req_seed  = s;
        start_req = 1'b1;
        cyc();
        k = 0;
        do begin
            cyc();
            k++;
        end while (!done && k < budget);
        check("run_done", done, 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_reqs = '0; seed = '0;
        operands_rdy = 1'b0; result_val = 1'b0; result_bits_data = '0;
        model_on = 1'b1; inj_val = 1'b0; inj_data = '0; start_req = 1'b0;
        req_n = '0; req_seed = '0; exp_a = '0; exp_b = '0;
        lat = 2; stall = 0; ncyc = 0; busy_cyc = 0; saw_val = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_a", operands_bits_A, 0);
        check("rst_b", operands_bits_B, 0);
        check("rst_val", operands_val, 0);
        check("rst_rrdy", result_rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_sum", checksum, 0);
        check("rst_resp", resp_count, 0);
        check("rst_cyc", cycle_count, 0);
        reset = 1'b0;

        // Two requests from seed 1
        run(2, 16'h0001, 60);
        check("t1_nfire", log_a.size(), 2);
        check("t1_a0", log_a[0], 16'h0001);
        check("t1_b0", log_b[0], 16'h0100);
        check("t1_a1", log_a[1], 16'h0002);
        check("t1_b1", log_b[1], 16'h0200);
        check("t1_sum", checksum, 16'h0000);
        check("t1_resp", resp_count, 2);
        check("t1_err", err, 0);
        check("t1_busy", busy, 0);
        check("t1_val", operands_val, 0);
        check("t1_rrdy", result_rdy, 0);
        check("t1_cyc", cycle_count, busy_cyc);

        // Zero seed replaced by 1
        run(1, 16'h0000, 60);
        check("t2_a0", log_a[0], 16'h0001);
        check("t2_b0", log_b[0], 16'h0100);
        check("t2_sum", checksum, 16'h0001);
        check("t2_resp", resp_count, 1);

        // Backpressure: five stalled cycles after val rises
        stall = 5; exp_a = 16'h1234; exp_b = 16'h3412;
        run(1, 16'h1234, 60);
        check("t3_stall_used", stall, 0);
        check("t3_nfire", log_a.size(), 1);
        check("t3_a0", log_a[0], 16'h1234);
        check("t3_b0", log_b[0], 16'h3412);
        check("t3_sum", checksum, 16'h000A);
        check("t3_cyc", cycle_count, busy_cyc);
        check("t3_cyc_min", cycle_count >= 32'(6 + lat), 1);
        stall = 0;

        // Zero requests
        run(0, 16'h5555, 10);
        check("t4_busy_cyc", busy_cyc, 1);
        check("t4_cyc", cycle_count, 1);
        check("t4_saw_val", saw_val, 0);
        check("t4_sum", checksum, 0);
        check("t4_resp", resp_count, 0);

        // Unsolicited result before any operand fire
        model_on = 1'b0; inj_val = 1'b1; inj_data = 16'h0005;
        run(1, 16'h0001, 10);
        check("t5_err", err, 1);
        check("t5_sum", checksum, 16'h0005);
        check("t5_resp", resp_count, 1);
        check("t5_nfire", log_a.size(), 0);
        inj_val = 1'b0;
        repeat (3) cyc();
        check("t5_err_sticky", err, 1);
        model_on = 1'b0;
        rq_data.delete(); rq_due.delete();
        model_on = 1'b1;
        run(1, 16'h0001, 60);
        check("t5_err_clr", err, 0);
        check("t5_sum2", checksum, 16'h0001);

        // Reset with three of four requests outstanding
        lat = 40;
        log_a.delete(); log_b.delete();
        req_n = CNT_W'(4); req_seed = 16'h00AC; start_req = 1'b1;
        cyc();
        for (int k = 0; k < 20 && log_a.size() < 3; k++) cyc();
        @(posedge clk);
        #1;
        check("t6_pre_busy", busy, 1);
        check("t6_pre_val", operands_val, 1);
        reset = 1'b1;
        #1;
        check("t6_val", operands_val, 0);
        check("t6_rrdy", result_rdy, 0);
        check("t6_busy", busy, 0);
        check("t6_a", operands_bits_A, 0);
        check("t6_b", operands_bits_B, 0);
        check("t6_done", done, 0);
        check("t6_sum", checksum, 0);
        check("t6_resp", resp_count, 0);
        check("t6_cyc", cycle_count, 0);
        #2;
        reset = 1'b0;
        rq_data.delete(); rq_due.delete();
        lat = 2;
        run(1, 16'h0003, 60);
        check("t6_a0", log_a[0], 16'h0003);
        check("t6_b0", log_b[0], 16'h0300);
        check("t6_sum2", checksum, 16'h0003);
        check("t6_resp2", resp_count, 1);
        check("t6_err2", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
